// File: rtl/sm_gpio_in_pkg.sv
// Shared constants and types for the GPIO input block.
// WIDTH/DEBOUNCE defaults mirror the CPU's shared configuration so widths agree.
package sm_gpio_in_pkg;

  localparam int unsigned SM_CPU_DATA_W        = 8;
  localparam int unsigned SM_CPU_GPIO_DEBOUNCE = 16;

  // Per-bit view handed from the debouncer to the flag logic.
  typedef struct packed {
    logic level;  // current registered exData bit
    logic load;   // exData bit flips to ~level on the coming edge
  } db_status_t;

  // ceil(log2(cycles)), never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/sm_gpio_in_if.sv
// Signal bundle for the GPIO input block: pins, flag control and CPU-facing outputs.
interface sm_gpio_in_if
  import sm_gpio_in_pkg::*;
#(
  parameter int unsigned WIDTH = SM_CPU_DATA_W
);

  logic [WIDTH-1:0] gpio_in;
  logic [WIDTH-1:0] exData;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] irq_en;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             changed;
  logic             irq;

  modport master (
    output gpio_in, clr, irq_en,
    input  exData, rise, fall, changed, irq
  );

  modport slave (
    input  gpio_in, clr, irq_en,
    output exData, rise, fall, changed, irq
  );

endinterface

// File: rtl/sm_gpio_in_debounce_bit.sv
// One GPIO bit: two-flop synchronizer, optional stability counter, exData bit.
// Counter present only with SM_GPIO_IN_DEBOUNCE_EN; otherwise sync2 loads every cycle.
module sm_debounce_bit
  import sm_gpio_in_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = SM_CPU_GPIO_DEBOUNCE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pin_i,
  output db_status_t status_o
);

  logic sync1_q;
  logic sync2_q;
  logic level_q;
  logic load;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef SM_GPIO_IN_DEBOUNCE_EN
  localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Any return to the accepted level restarts qualification from zero.
  always_comb begin
    cnt_d = cnt_q;
    load  = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      load  = 1'b1;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // A zero setting is out of range; freeze the bit rather than pass it through.
  localparam logic CFG_OK = (DEBOUNCE_CYCLES != 0);

  assign load = CFG_OK & (sync2_q != level_q);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q <= 1'b0;
    end else if (load) begin
      level_q <= sync2_q;
    end
  end

  assign status_o.level = level_q;
  assign status_o.load  = load;

endmodule

// File: rtl/sm_gpio_in.sv
// GPIO input block: per-bit debounced exData, sticky edge flags, change strobe, irq.
// Build option SM_GPIO_IN_DEBOUNCE_EN enables the per-bit stability counters.
module sm_gpio_in
  import sm_gpio_in_pkg::*;
#(
  parameter int unsigned WIDTH           = SM_CPU_DATA_W,
  parameter int unsigned DEBOUNCE_CYCLES = SM_CPU_GPIO_DEBOUNCE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] exData,
  input  logic [WIDTH-1:0] clr,
  input  logic [WIDTH-1:0] irq_en,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed,
  output logic             irq
);

  db_status_t       st [WIDTH];
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] load;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sm_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk      (clk),
      .rst_n    (rst_n),
      .pin_i    (gpio_in[i]),
      .status_o (st[i])
    );
    assign level[i] = st[i].level;
    assign load[i]  = st[i].load;
  end

  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             changed_q, changed_d;

  // A load always flips the bit, so the old level tells the edge direction.
  // Set is OR-ed after clear so a same-cycle set survives the clear.
  always_comb begin
    rise_d    = (rise_q & ~clr) | (load & ~level);
    fall_d    = (fall_q & ~clr) | (load & level);
    changed_d = |load;
  end

  // changed rises on the same edge as exData, covering the cycle that follows the update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  assign exData  = level;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign changed = changed_q;
  assign irq     = |((rise_q | fall_q) & irq_en);

endmodule

// File: doc/sm_gpio_in.md
SM_GPIO_IN -- requirements
Module: sm_gpio_in

Interface
REQ-001 SHALL have parameter: WIDTH, 8, number of GPIO input bits.
REQ-002 SHALL have parameter: DEBOUNCE_CYCLES, 16, consecutive cycles of stable differing input required before acceptance; legal range 1..65535.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port: gpio_in  input  WIDTH  raw asynchronous pin levels.
REQ-006 SHALL have port: exData  output  WIDTH  debounced, registered level; feeds the CPU's external-data input.
REQ-007 SHALL have port: clr  input  WIDTH  per-bit clear for the edge flags, sampled each cycle.
REQ-008 SHALL have port: irq_en  input  WIDTH  per-bit interrupt enable.
REQ-009 SHALL have port: rise  output  WIDTH  sticky rising-edge flags.
REQ-010 SHALL have port: fall  output  WIDTH  sticky falling-edge flags.
REQ-011 SHALL have port: changed  output  1  one-cycle strobe, high the cycle after any exData bit changes.
REQ-012 SHALL have port: irq  output  1  combinational OR of ((rise|fall) & irq_en).

Function
REQ-013 SHALL pass gpio_in through a two-flop synchronizer (sync1, then sync2) per bit before any other use.
REQ-014 SHALL keep one counter per bit, sized ceil(log2(DEBOUNCE_CYCLES)) bits (minimum 1).
REQ-015 SHALL, per bit each cycle: if sync2 equals exData, clear the counter; else if counter equals DEBOUNCE_CYCLES-1, load exData from sync2 and clear the counter; else increment the counter.
REQ-016 SHALL give latency of exactly DEBOUNCE_CYCLES+2 rising edges from a held change on gpio_in to exData updating.
REQ-017 SHALL never propagate to exData any pulse or glitch shorter than DEBOUNCE_CYCLES cycles at sync2; a bounce back to the exData level restarts the count from zero.
REQ-018 SHALL set rise[i] on the edge where exData[i] updates 0->1, and fall[i] on the edge where it updates 1->0.
REQ-019 SHALL hold flags until cleared by clr[i]=1; simultaneous set and clear of the same flag SHALL leave it set.
REQ-020 SHALL assert changed for exactly one cycle following any cycle where exData updates; independent bits updating together SHALL give a single strobe.
REQ-021 SHALL treat DEBOUNCE_CYCLES=1 as identical in timing to the bypass mode of REQ-026.

Reset
REQ-022 SHALL, while rst_n=0 at a clock edge, clear sync1, sync2, exData, all counters, rise, fall and changed to 0.
REQ-023 SHALL discard any in-progress debounce count on reset; a pin held high through reset SHALL re-qualify, appearing on exData DEBOUNCE_CYCLES+2 edges after rst_n rises, and setting rise.
REQ-024 SHALL have irq=0 during reset, since all flags are 0.

Configuration
REQ-025 SHALL, with macro SM_GPIO_IN_DEBOUNCE_EN defined, implement the counters of REQ-014 to REQ-017.
REQ-026 SHALL, with SM_GPIO_IN_DEBOUNCE_EN undefined, implement no counters, ignore DEBOUNCE_CYCLES, and load exData from sync2 every cycle (latency 3 edges); flags, changed and irq SHALL be unchanged in behaviour.

Structure
REQ-027 SHALL take the WIDTH and DEBOUNCE_CYCLES defaults from constants in the shared sm_cpu.vh header, so that CPU and GPIO widths agree.
REQ-028 SHALL implement the per-bit synchronizer, counter and exData bit as sub-module sm_debounce_bit, instantiated WIDTH times; flags, changed and irq SHALL live in the top module.

Verification
REQ-029 SHALL cover: DEBOUNCE_CYCLES=4, gpio_in 0x00->0x5A held -> exData=0x5A exactly 6 edges later, rise=0x5A, fall=0x00, changed high for exactly 1 cycle.
REQ-030 SHALL cover: DEBOUNCE_CYCLES=4, bit0 pulsed high for 3 cycles, then low -> exData, rise and changed stay 0.
REQ-031 SHALL cover: rise=0x01 with irq_en=0x01 -> irq=1; clr=0x01 in the same cycle that a new bit0 rise is accepted -> rise[0] stays 1; clr=0x01 alone next cycle -> rise=0, irq=0.
REQ-032 SHALL cover: DEBOUNCE_CYCLES=4, gpio_in=0xFF, rst_n pulsed low for 1 cycle at edge 4 of the count -> exData=0; exData=0xFF 6 edges after rst_n returns high.
REQ-033 SHALL cover: SM_GPIO_IN_DEBOUNCE_EN undefined, a 1-cycle pulse on bit7 -> exData[7] high for 1 cycle, 3 edges later; rise[7]=fall[7]=1.
